spi_master_ctrl: RTL and testbench

SPI initiator that drives the slave side of the SPI+RAM wrapper: serialises 10-bit command words onto MOSI under SS_n and, for read-data commands, captures the 8-bit reply from MISO. Single clock domain shared with the slave; the slave samples MOSI/SS_n on posedge clk, so no separate SCLK is generated. Sits between a host-side valid/ready command interface and the wrapper's SPI pins.

---
 rtl/spi_master_ctrl.sv | 146 ++++++++++++++
 tb/tb_spi_master_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_ctrl.sv
// SPI initiator: serialises 10-bit commands onto MOSI under SS_n and captures 8-bit replies on rd-data frames.
// Optional frame counter output enabled by defining SPI_MASTER_FRAME_CNT_EN.
module spi_master_ctrl #(
  parameter int TURNAROUND = 2,
  parameter int GAP        = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [9:0] cmd_data,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
`ifdef SPI_MASTER_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SEL   = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_RECV  = 3'd5;
  localparam logic [2:0] S_GAP   = 3'd6;

  localparam logic [3:0] TA_LAST  = 4'(TURNAROUND - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

  logic [2:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [9:0] cmd_q, cmd_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       rd_valid_q, rd_valid_d;

  assign cmd_ready = rst_n && (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign SS_n      = (state_q == S_IDLE) || (state_q == S_GAP);
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;

  always_comb begin
    MOSI = 1'b0;
    case (state_q)
      S_SEL:   MOSI = cmd_q[9];
      S_SHIFT: MOSI = cmd_q[4'd9 - cnt_q];
      default: MOSI = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    rx_sh_d    = rx_sh_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    case (state_q)
      S_IDLE: if (cmd_valid && cmd_ready) begin
        cmd_d   = cmd_data;
        state_d = S_SEL;
        cnt_d   = 4'd0;
      end
      S_SEL: begin
        state_d = S_SHIFT;
        cnt_d   = 4'd0;
      end
      S_SHIFT: if (cnt_q == 4'd9) begin
        state_d = (cmd_q[9:8] == 2'b11) ? S_WAIT : S_HOLD;
        cnt_d   = 4'd0;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
      S_HOLD: begin
        state_d = S_GAP;
        cnt_d   = 4'd0;
      end
      S_WAIT: if (cnt_q == TA_LAST) begin
        state_d = S_RECV;
        cnt_d   = 4'd0;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
      S_RECV: begin
        rx_sh_d = {rx_sh_q[6:0], MISO};
        if (cnt_q == 4'd7) begin
          // Reply lands together with the first GAP cycle.
          rd_data_d  = {rx_sh_q[6:0], MISO};
          rd_valid_d = 1'b1;
          state_d    = S_GAP;
          cnt_d      = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_GAP: if (cnt_q == GAP_LAST) begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      cmd_q      <= 10'd0;
      rx_sh_q    <= 8'd0;
      rd_data_q  <= 8'd0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      rx_sh_q    <= rx_sh_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

`ifdef SPI_MASTER_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;
  assign frame_cnt = frame_cnt_q;

  // Only frames that reach GAP count; reset aborts never get there.
  always_ff @(posedge clk) begin
    if (!rst_n)
      frame_cnt_q <= 16'd0;
    else if (state_d == S_GAP && state_q != S_GAP)
      frame_cnt_q <= frame_cnt_q + 16'd1;
  end
`endif

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed self-checking bench for spi_master_ctrl at default TURNAROUND=2, GAP=1.
module tb_spi_master_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [9:0] cmd_data;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       busy;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
`ifdef SPI_MASTER_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  int checks = 0;
  int errors = 0;

  spi_master_ctrl #(.TURNAROUND(2), .GAP(1)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy),
    .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
`ifdef SPI_MASTER_FRAME_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Drives one command and records the frame; the slave reply is shifted out on the 8 RECV cycles.
  task automatic run_frame(input logic [9:0] c, input logic [7:0] rep, output int len,
                           output logic [31:0] bits, output int nrdv, output logic [7:0] rdd,
                           output int rdv_pos, output int hi_len, output bit ok);
    int n = 0;
    len = 0; bits = 0; nrdv = 0; rdd = 8'h00; rdv_pos = -1; hi_len = 0; ok = 1'b1;
    cmd_valid = 1'b1; cmd_data = c;
    while (!cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!cmd_ready) ok = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_data = 10'h3FF;
    while (!SS_n && len < 40) begin
      bits = {bits[30:0], MOSI};
      MISO = (len >= 13 && len < 21) ? rep[20-len] : 1'b0;
      if (rd_valid) nrdv++;
      @(posedge clk); #1;
      len++;
    end
    MISO = 1'b0;
    while (!cmd_ready && hi_len < 20) begin
      if (rd_valid) begin nrdv++; rdd = rd_data; rdv_pos = hi_len; end
      @(posedge clk); #1;
      hi_len++;
    end
    if (!cmd_ready) ok = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b1; cmd_data = 10'h3FF; MISO = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if ({SS_n, MOSI, cmd_ready, rd_valid, busy} !== 5'b10000) begin
        errors++;
        $display("FAIL reset_outputs got SS_n/MOSI/ready/rdv/busy=%b required 10000",
                 {SS_n, MOSI, cmd_ready, rd_valid, busy});
      end
      checks++;
      if (rd_data !== 8'h00) begin
        errors++; $display("FAIL reset_rd_data got %h required 00", rd_data);
      end
    end
    rst_n = 1'b1; cmd_valid = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready got %b required 1", cmd_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write();
    int len, nrdv, rdv_pos, hi_len; logic [31:0] bits; logic [7:0] rdd; bit ok;
    run_frame(10'h0A5, 8'h00, len, bits, nrdv, rdd, rdv_pos, hi_len, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL wr_handshake timed out"); end
    checks++;
    if (len !== 12) begin errors++; $display("FAIL wr_len got %0d required 12", len); end
    checks++;
    if (bits[11:0] !== 12'h14A) begin
      errors++; $display("FAIL wr_mosi got %h required 14a", bits[11:0]);
    end
    checks++;
    if (hi_len !== 1) begin errors++; $display("FAIL wr_gap got %0d required 1", hi_len); end
    checks++;
    if (nrdv !== 0) begin errors++; $display("FAIL wr_rdvalid got %0d required 0", nrdv); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_end got %b required 0", busy); end
  endtask

  task automatic test_read();
    int len, nrdv, rdv_pos, hi_len; logic [31:0] bits; logic [7:0] rdd; bit ok;
    run_frame(10'h300, 8'h3C, len, bits, nrdv, rdd, rdv_pos, hi_len, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rd_handshake timed out"); end
    checks++;
    if (len !== 21) begin errors++; $display("FAIL rd_len got %0d required 21", len); end
    checks++;
    if (bits[20:8] !== 13'h1C00) begin
      errors++; $display("FAIL rd_mosi got %h required 1c00", bits[20:8]);
    end
    checks++;
    if (nrdv !== 1 || rdv_pos !== 0) begin
      errors++; $display("FAIL rd_valid_pulse got count %0d pos %0d required 1 0", nrdv, rdv_pos);
    end
    checks++;
    if (rdd !== 8'h3C) begin errors++; $display("FAIL rd_data got %h required 3c", rdd); end
    checks++;
    if (hi_len !== 1 || busy !== 1'b0) begin
      errors++; $display("FAIL rd_busy_fall got gap %0d busy %b required 1 0", hi_len, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0]  cmds [4] = '{10'h012, 10'h155, 10'h2AB, 10'h300};
    logic [11:0] expw [3] = '{12'h024, 12'h2AA, 12'hD56};
    int lens [4]; logic [31:0] fb [4]; int gaps [3];
    int nacc = 0, nfr = 0, low = 0, hi = 0, nrdv = 0, stray = 0;
    logic [31:0] bits = 0; logic [7:0] rdd = 8'h00, rdd_mid = 8'h00, rep = 8'h5A;
    bit acc;
    for (int i = 0; i < 4; i++) begin lens[i] = 0; fb[i] = 0; end
    for (int i = 0; i < 3; i++) gaps[i] = 0;
    cmd_data = cmds[0]; cmd_valid = 1'b1;
    for (int cyc = 0; cyc < 150 && nfr < 4; cyc++) begin
      acc = cmd_valid && cmd_ready;
      if (rd_valid) begin nrdv++; rdd = rd_data; end
      if (!SS_n) begin
        if (low == 0) begin bits = 0; if (nfr > 0) gaps[nfr-1] = hi; end
        bits = {bits[30:0], MOSI};
        MISO = (low >= 13 && low < 21) ? rep[20-low] : 1'b0;
        low++;
      end else begin
        MISO = 1'b0;
        if (low > 0) begin
          if (nfr == 2) rdd_mid = rd_data;
          lens[nfr] = low; fb[nfr] = bits; nfr++; hi = 0;
        end
        low = 0; hi++;
      end
      @(posedge clk); #1;
      if (acc) begin
        nacc++;
        if (nacc < 4) cmd_data = cmds[nacc]; else cmd_valid = 1'b0;
      end
    end
    repeat (5) begin
      if (!SS_n || rd_valid) stray++;
      @(posedge clk); #1;
    end
    checks++;
    if (nacc !== 4 || nfr !== 4) begin
      errors++; $display("FAIL b2b_count got acc %0d frames %0d required 4 4", nacc, nfr);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (lens[i] !== 12 || fb[i][11:0] !== expw[i]) begin
        errors++; $display("FAIL b2b_frame%0d got len %0d bits %h required 12 %h", i, lens[i], fb[i][11:0], expw[i]);
      end
      checks++;
      if (gaps[i] !== 2) begin errors++; $display("FAIL b2b_gap%0d got %0d required 2", i, gaps[i]); end
    end
    checks++;
    if (lens[3] !== 21 || fb[3][20:8] !== 13'h1C00) begin
      errors++; $display("FAIL b2b_frame3 got len %0d bits %h required 21 1c00", lens[3], fb[3][20:8]);
    end
    checks++;
    if (rdd_mid !== 8'h3C) begin errors++; $display("FAIL b2b_rd_hold got %h required 3c", rdd_mid); end
    checks++;
    if (nrdv !== 1 || rdd !== 8'h5A) begin
      errors++; $display("FAIL b2b_rd got count %0d data %h required 1 5a", nrdv, rdd);
    end
    checks++;
    if (stray !== 0) begin errors++; $display("FAIL b2b_extra got %0d required 0", stray); end
  endtask

  task automatic test_reset_mid_shift();
    int len, nrdv, rdv_pos, hi_len, rv = 0; logic [31:0] bits; logic [7:0] rdd; bit ok;
    cmd_valid = 1'b1; cmd_data = 10'h2C3;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    checks++;
    if (SS_n !== 1'b0) begin errors++; $display("FAIL abort_inframe got SS_n %b required 0", SS_n); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({SS_n, MOSI, busy} !== 3'b100) begin
      errors++; $display("FAIL abort_ss got SS_n/MOSI/busy %b required 100", {SS_n, MOSI, busy});
    end
    if (rd_valid) rv++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin if (rd_valid) rv++; @(posedge clk); #1; end
    checks++;
    if (rv !== 0) begin errors++; $display("FAIL abort_rdvalid got %0d required 0", rv); end
    run_frame(10'h15A, 8'h00, len, bits, nrdv, rdd, rdv_pos, hi_len, ok);
    checks++;
    if (!ok || len !== 12 || bits[11:0] !== 12'h2B4) begin
      errors++; $display("FAIL abort_next_frame got ok %0d len %0d bits %h required 1 12 2b4", ok, len, bits[11:0]);
    end
  endtask

`ifdef SPI_MASTER_FRAME_CNT_EN
  task automatic test_frame_cnt();
    int len, nrdv, rdv_pos, hi_len; logic [31:0] bits; logic [7:0] rdd; bit ok;
    rst_n = 1'b0; repeat (2) @(posedge clk); #1; rst_n = 1'b1;
    for (int i = 0; i < 3; i++) run_frame(10'h0A5, 8'h00, len, bits, nrdv, rdd, rdv_pos, hi_len, ok);
    checks++;
    if (frame_cnt !== 16'd3) begin errors++; $display("FAIL fcnt_three got %0d required 3", frame_cnt); end
    cmd_valid = 1'b1; cmd_data = 10'h0A5;
    @(posedge clk); #1; cmd_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    checks++;
    if (frame_cnt !== 16'd3) begin errors++; $display("FAIL fcnt_partial got %0d required 3", frame_cnt); end
    rst_n = 1'b0; @(posedge clk); #1; rst_n = 1'b1;
    checks++;
    if (frame_cnt !== 16'd0) begin errors++; $display("FAIL fcnt_abort got %0d required 0", frame_cnt); end
  endtask
`endif

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_data = 10'h000; MISO = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_reset_mid_shift();
`ifdef SPI_MASTER_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
